alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the single-cycle execute ALU. It accepts one operation per transaction on a valid/ready input port and returns a registered result plus a flag on a valid/ready output port. Supported work: add/sub with carry/borrow, logical and arithmetic shifts, half-word load, pass-through, unsigned compares, and an iterative shift-add multiply. It sits between decode and register writeback; the branch unit consumes its `flag`.

## Interface
- `WIDTH`, 32, datapath width; even, ≥ 8.
- `SHW`, $clog2(WIDTH), shift-amount width; derived, not overridden.

- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: block can accept an operation.
- `op` in 4: opcode.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B or shift amount.
- `value` in WIDTH/2: immediate half-word for LOAD.
- `highlow` in 1: LOAD target half; 1 = upper, 0 = lower.
- `out_valid` out 1: `result` and `flag` valid.
- `out_ready` in 1: consumer takes result.
- `result` out WIDTH: registered result.
- `flag` out 1: registered carry, borrow, compare or overflow flag.
- `busy` out 1: multiply in progress.

## Operation
- Opcodes, with result / flag:
  - 0 ADD: a+b mod 2^WIDTH / carry-out.
  - 1 SUB: a−b (two's complement) / borrow, i.e. a<b unsigned.
  - 2 SHL: a<<b, zero-fill / 0.
  - 3 SHR: a>>b, zero-fill / 0.
  - 4 PASS: a / 0.
  - 5 LOAD: highlow=1 gives {value, a[WIDTH/2-1:0]}; highlow=0 gives {a[WIDTH-1:WIDTH/2], value} / 0.
  - 6 SRA: a>>>b, sign-fill / 0.
  - 8 EQ: result 0 / a==b.
  - 9 LTU: result 0 / a<b.
  - 10 GTU: result 0 / a>b.
  - 11 MUL: low WIDTH bits of a*b unsigned / 1 if the high WIDTH bits are non-zero.
  - 7, 12–15: illegal. Result 0, flag 0; the transaction still completes normally.
- Shifts:
  - If b ≥ WIDTH (any bit above SHW−1 set, or the value ≥ WIDTH): SHL and SHR give 0; SRA gives all copies of a[WIDTH−1].
  - Otherwise the shift amount is b[SHW−1:0].
- FSM states: IDLE, MUL, HOLD.
  - IDLE: an accept (in_valid & in_ready) of a non-MUL op registers result/flag and goes to HOLD. Accept of MUL latches operands, clears the accumulator, loads the counter with WIDTH and goes to MUL.
  - MUL: each cycle, if multiplier LSB=1 then add the multiplicand to the 2·WIDTH accumulator; shift the multiplicand left and the multiplier right; decrement the counter. When the counter reaches 0, register result/flag and go to HOLD.
  - HOLD: out_valid=1. On out_ready=1: if in_valid=1 with a non-MUL op, accept it back-to-back and stay in HOLD with the new result. If in_valid=1 with MUL, go to MUL. Otherwise go to IDLE.
- `in_ready` = (state==IDLE) | (state==HOLD & out_ready). Combinational; it never depends on in_valid.
- `busy` = (state==MUL).
- Operand inputs are sampled only on accept; changing them at any other time has no effect.
- Reset (asserted asynchronously, at any time including mid-MUL): state IDLE, out_valid 0, result 0, flag 0, counter 0, accumulator 0. An in-flight operation is discarded with no output.

## Timing
- Non-MUL latency: accept at edge N, out_valid=1 after edge N; one op per cycle sustained while out_ready=1.
- MUL latency: accept at edge N, out_valid=1 after edge N+WIDTH (WIDTH+1 cycles including the accept cycle). in_ready=0 throughout MUL.
- Backpressure: while out_valid & ~out_ready, result and flag are held stable and in_ready=0.
- Outputs after reset release: in_ready=1, out_valid=0, busy=0, result=0, flag=0.

## Test plan
- ADD a=0xFFFFFFFF b=1, out_ready=1 -> result 0x00000000, flag 1, out_valid exactly one cycle after accept; SUB 3−5 -> 0xFFFFFFFE, flag 1.
- Shifts: SHR 0x80000000 by 31 -> 0x00000001; SRA 0x80000000 by 4 -> 0xF8000000; SHL 0x1 by 32 -> 0; SRA 0x80000000 by 40 -> 0xFFFFFFFF.
- LOAD a=0x12345678 value=0xABCD: highlow=1 -> 0xABCD5678; highlow=0 -> 0x1234ABCD. Op 13 -> result 0, flag 0.
- MUL 0x00010000 × 0x00010000 -> result 0, flag 1, out_valid 32 edges after accept, busy=1 and in_ready=0 during MUL; MUL 7×6 -> 42, flag 0.
- Back-to-back EQ(7,7), LTU(2,9), GTU(2,9) with out_ready=1 -> flags 1, 1, 0 on three consecutive cycles. Hold out_ready=0 for 5 cycles -> result and flag stable, in_ready=0.
- Pulse reset_n low for 1 cycle at MUL cycle 10 -> out_valid, busy and result go to 0 immediately; in_ready=1 after release; the next ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flag and iterative shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH/2-1:0] value,
  input  logic               highlow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  localparam logic [3:0] OP_MUL = 4'd11;
  state_t state;
  logic [2*WIDTH-1:0] acc, mcand, acc_n;
  logic [WIDTH-1:0] mplier, res_c;
  logic [SHW:0] cnt;
  logic [WIDTH:0] sum, dif;
  logic [SHW-1:0] sh;
  logic big, flg_c, take;
  assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
  assign out_valid = state == HOLD;
  assign busy = state == MUL;
  assign take = in_valid & in_ready;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign sh = b[SHW-1:0];
  assign big = b >= WIDTH'(WIDTH);
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  // single-cycle result and flag for every non-multiply opcode
  always_comb begin
    res_c = '0;
    flg_c = 1'b0;
    case (op)
      4'd0: {flg_c, res_c} = sum;
      4'd1: {flg_c, res_c} = dif;
      4'd2: res_c = big ? '0 : a << sh;
      4'd3: res_c = big ? '0 : a >> sh;
      4'd4: res_c = a;
      4'd5: res_c = highlow ? {value, a[WIDTH/2-1:0]} : {a[WIDTH-1:WIDTH/2], value};
      4'd6: res_c = big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> sh);
      4'd8: flg_c = a == b;
      4'd9: flg_c = a < b;
      4'd10: flg_c = a > b;
      default: ;
    endcase
  end
  // control FSM, multiply datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      result <= '0;
      flag <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (state == MUL) begin
      acc <= acc_n;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
      if (cnt == 1) begin
        result <= acc_n[WIDTH-1:0];
        flag <= |acc_n[2*WIDTH-1:WIDTH];
        state <= HOLD;
      end
    end else if (take) begin
      if (op == OP_MUL) begin
        mcand <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc <= '0;
        cnt <= (SHW+1)'(WIDTH);
        state <= MUL;
      end else begin
        result <= res_c;
        flag <= flg_c;
        state <= HOLD;
      end
    end else if (out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with a queued scoreboard checked by an output monitor
module tb_alu_pipe;
  typedef struct {string name; logic [31:0] r; logic f;} exp_t;
  logic clock, reset_n, in_valid, in_ready, highlow, out_valid, out_ready, flag, busy;
  logic [3:0] op;
  logic [31:0] a, b, result;
  logic [15:0] value;
  exp_t q[$];
  int checks = 0, failures = 0;
  alu_pipe #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .value(value), .highlow(highlow),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag(flag), .busy(busy)
  );
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  // monitor: pop and compare on every output handshake
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, result, e.r);
        chk({e.name, "_flag"}, {31'd0, flag}, {31'd0, e.f});
      end
    end
  end
  // called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input string name, input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                      input logic [15:0] v, input logic hl, input logic [31:0] er, input logic ef);
    int n = 0;
    op = o; a = xa; b = xb; value = v; highlow = hl; in_valid = 1;
    @(negedge clock);
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) chk({name, "_accept_timeout"}, 32'd1, 32'd0);
    else q.push_back('{name, er, ef});
    @(posedge clock);
    #1 in_valid = 0;
  endtask
  initial begin
    int c;
    logic bad;
    logic [31:0] hr;
    logic hf;
    reset_n = 0; in_valid = 0; out_ready = 1; op = 0; a = 0; b = 0; value = 0; highlow = 0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    @(posedge clock); #1;
    send("add_carry", 4'd0, 32'hFFFFFFFF, 32'd1, 16'd0, 0, 32'h0, 1);
    @(negedge clock);
    chk("add_latency", {31'd0, out_valid}, 32'd1);
    @(posedge clock); #1;
    send("sub_borrow", 4'd1, 32'd3, 32'd5, 16'd0, 0, 32'hFFFFFFFE, 1);
    send("shr31", 4'd3, 32'h80000000, 32'd31, 16'd0, 0, 32'h00000001, 0);
    send("sra4", 4'd6, 32'h80000000, 32'd4, 16'd0, 0, 32'hF8000000, 0);
    send("shl32", 4'd2, 32'h00000001, 32'd32, 16'd0, 0, 32'h0, 0);
    send("sra40", 4'd6, 32'h80000000, 32'd40, 16'd0, 0, 32'hFFFFFFFF, 0);
    send("shl4", 4'd2, 32'h0000000F, 32'd4, 16'd0, 0, 32'h000000F0, 0);
    send("load_hi", 4'd5, 32'h12345678, 32'd0, 16'hABCD, 1, 32'hABCD5678, 0);
    send("load_lo", 4'd5, 32'h12345678, 32'd0, 16'hABCD, 0, 32'h1234ABCD, 0);
    send("illegal13", 4'd13, 32'd5, 32'd3, 16'd0, 0, 32'h0, 0);
    send("pass", 4'd4, 32'hDEADBEEF, 32'd1, 16'd0, 0, 32'hDEADBEEF, 0);
    send("mul_big", 4'd11, 32'h00010000, 32'h00010000, 16'd0, 0, 32'h0, 1);
    c = 0; bad = 0;
    @(negedge clock);
    while (!out_valid && c < 100) begin
      if (!busy || in_ready) bad = 1;
      @(negedge clock);
      c++;
    end
    chk("mul_latency", c, 32'd32);
    chk("mul_busy_noready", {31'd0, bad}, 32'd0);
    @(posedge clock); #1;
    send("mul_7x6", 4'd11, 32'd7, 32'd6, 16'd0, 0, 32'd42, 0);
    c = 0;
    @(negedge clock);
    while (!out_valid && c < 100) begin @(negedge clock); c++; end
    @(posedge clock); #1;
    send("eq", 4'd8, 32'd7, 32'd7, 16'd0, 0, 32'h0, 1);
    send("ltu", 4'd9, 32'd2, 32'd9, 16'd0, 0, 32'h0, 1);
    send("gtu", 4'd10, 32'd2, 32'd9, 16'd0, 0, 32'h0, 0);
    @(posedge clock); #1;
    out_ready = 0;
    send("bp_sub", 4'd1, 32'd1, 32'd2, 16'd0, 0, 32'hFFFFFFFF, 1);
    @(negedge clock);
    hr = result; hf = flag; bad = 0;
    chk("bp_result_first", hr, 32'hFFFFFFFF);
    repeat (5) begin
      @(negedge clock);
      if (result !== hr || flag !== hf || in_ready || !out_valid) bad = 1;
    end
    chk("bp_stable", {31'd0, bad}, 32'd0);
    @(posedge clock); #1 out_ready = 1;
    @(posedge clock); #1;
    send("pass2", 4'd4, 32'h0000BEEF, 32'd0, 16'd0, 0, 32'h0000BEEF, 0);
    send("mul_rst", 4'd11, 32'd3, 32'd3, 16'd0, 0, 32'd9, 0);
    repeat (9) @(posedge clock);
    #1 reset_n = 0;
    void'(q.pop_back());
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(posedge clock); #1 reset_n = 1;
    @(negedge clock);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    send("add_after_rst", 4'd0, 32'd1, 32'd1, 16'd0, 0, 32'd2, 0);
    repeat (4) @(negedge clock);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
